shift_concat: RTL and testbench
===============================

SHIFT_CONCAT -- requirements
Module: shift_concat

Interface
REQ-001 Parameter DATA_W, default 64, output word width in bits.
REQ-002 Parameter CNT_W, default 7, width of bit-count fields; holds 0..DATA_W.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  freezes all state while high (from control block).
REQ-006 in_valid  input  1  compressor output chunk present.
REQ-007 in_data  input  DATA_W  chunk bits, LSB-aligned.
REQ-008 in_bits  input  CNT_W  number of valid bits in in_data, legal 0..64.
REQ-009 flush  input  1  request to emit the residual partial word.
REQ-010 in_rdy  output  1  chunk/flush accepted this cycle when high.
REQ-011 out_data  output  DATA_W  packed word; partial words zero-padded at the top.
REQ-012 out_bits  output  CNT_W  valid bits in out_data: 64 for a full word, 1..63 for a flush residual.
REQ-013 scon_done  output  1  one-cycle pulse; out_data/out_bits are valid.
REQ-014 fill  output  CNT_W  bits currently held in the accumulator, 0..63.
REQ-015 error_bits  output  1  one-cycle pulse; an illegal in_bits chunk was dropped.

Function
REQ-016 in_rdy SHALL equal ~stall & ~flush_pend, combinationally.
REQ-017 A chunk SHALL be accepted when in_valid & in_rdy; in_data bits at and above in_bits SHALL be masked to zero.
REQ-018 An accepted chunk SHALL be merged at accumulator position fill; combined count n = fill + in_bits (0..127).
REQ-019 If n >= 64: out_data <= combined[63:0], out_bits <= 64, scon_done <= 1 next edge, accumulator <= combined >> 64, fill <= n - 64.
REQ-020 If n < 64: accumulator holds the merge, fill <= n, scon_done <= 0.
REQ-021 An accepted in_bits = 0 chunk SHALL change no state.
REQ-022 An accepted chunk with in_bits > 64 SHALL be dropped, state unchanged, error_bits pulsed for one cycle.
REQ-023 flush sampled with in_rdy high SHALL set flush_pend; a chunk in the same cycle is merged first per REQ-018..020.
REQ-024 The first non-stalled cycle with flush_pend set SHALL emit the residual: out_data = accumulator zero-padded, out_bits = fill, scon_done pulse, fill <= 0, flush_pend cleared.
REQ-025 If fill = 0 when a pending flush executes, scon_done SHALL stay low and flush_pend SHALL clear.
REQ-026 Consequence: a chunk completing a word in the flush cycle yields back-to-back scon_done pulses (full word, then residual).
REQ-027 While stall is high: no acceptance, scon_done and error_bits low, accumulator, fill, flush_pend, out_data and out_bits held.
REQ-028 out_data and out_bits SHALL hold their last emitted values between scon_done pulses.
REQ-029 Throughput: one chunk per cycle; emission latency one cycle after acceptance.

Reset
REQ-030 rst high SHALL immediately clear accumulator, fill, flush_pend, out_data, out_bits, scon_done and error_bits to 0.
REQ-031 in_rdy SHALL follow REQ-016 during and after reset (high unless stalled).
REQ-032 Reset mid-accumulation SHALL discard partial bits without emitting them.

Structure
REQ-033 Shared package dsec_pkg SHALL hold DATA_W, CNT_W, ACC_W (= 2*DATA_W) and MAX_CHUNK (= 64).
REQ-034 The combinational mask/shift/merge SHALL be one sub-module, shift_concat_merge (inputs: accumulator, fill, in_data, in_bits; output: combined, n).
REQ-035 Sequencing, flush and error logic SHALL stay in shift_concat.

Verification
REQ-036 Two chunks, 40 bits 0xAA..AA, then 24 bits 0x123456 -> one scon_done, out_data = {0x123456, 40-bit chunk}, out_bits = 64, fill = 0.
REQ-037 Chunks of 60 then 10 bits -> scon_done after the second, fill = 6, residual holds chunk-2 bits [9:4]; then flush -> next cycle out_bits = 6, fill = 0.
REQ-038 fill = 30, chunk of 64 bits with flush asserted -> scon_done two consecutive cycles, out_bits 64 then 30, in_rdy low for one cycle.
REQ-039 in_bits = 65 with fill = 12 -> error_bits pulse, fill stays 12, no scon_done.
REQ-040 stall held 3 cycles with in_valid high -> in_rdy low, no state change; rst pulsed with fill = 20 -> fill = 0, no emission.

Source files
------------

// File: rtl/dsec_pkg.sv
// -----------------------------------------------------------------------------
// dsec_pkg
// Shared constants for the shift/concatenate packer and its neighbours.
//   DATA_W    : packed output word width in bits
//   CNT_W     : width of every bit-count field (must hold 0..DATA_W)
//   ACC_W     : width of the merge result (accumulator plus one full chunk)
//   MAX_CHUNK : largest legal chunk length in bits
// -----------------------------------------------------------------------------
package dsec_pkg;

   localparam int DATA_W    = 64;
   localparam int CNT_W     = 7;
   localparam int ACC_W     = 2 * DATA_W;
   localparam int MAX_CHUNK = 64;

endpackage : dsec_pkg

// File: rtl/shift_concat_merge.sv
// -----------------------------------------------------------------------------
// shift_concat_merge
// Purely combinational datapath: masks an incoming chunk to its declared
// length, shifts it up to the current fill position and ORs it onto the
// accumulator contents.
// Ports:
//   acc_i      in  DATA_W    accumulator contents, zero above fill_i
//   fill_i     in  CNT_W     bits currently held in acc_i (0..DATA_W-1)
//   in_data_i  in  DATA_W    chunk bits, LSB-aligned, upper bits may be junk
//   in_bits_i  in  CNT_W     declared chunk length
//   combined_o out 2*DATA_W  merged bit string, LSB = oldest bit
//   n_o        out CNT_W+1   fill_i + in_bits_i
// -----------------------------------------------------------------------------
module shift_concat_merge #(
   parameter int DATA_W = dsec_pkg::DATA_W,
   parameter int CNT_W  = dsec_pkg::CNT_W
) (
   input  logic [DATA_W-1:0]   acc_i,
   input  logic [CNT_W-1:0]    fill_i,
   input  logic [DATA_W-1:0]   in_data_i,
   input  logic [CNT_W-1:0]    in_bits_i,
   output logic [2*DATA_W-1:0] combined_o,
   output logic [CNT_W:0]      n_o
);

   localparam int ACC_W = 2 * DATA_W;

   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] masked;

   // NOTE: every variable written here gets a value before any conditional
   //       path, so no storage (latch) can be inferred.
   always_comb begin
      mask = '1;
      // Lengths of DATA_W and above keep the full word; illegal lengths are
      // rejected by the sequencer, so their merge result is never used.
      if (in_bits_i < CNT_W'(DATA_W)) begin
         mask = ~({DATA_W{1'b1}} << in_bits_i);
      end
      masked     = in_data_i & mask;
      combined_o = {{DATA_W{1'b0}}, acc_i}
                 | ({{DATA_W{1'b0}}, masked} << fill_i);
      n_o        = {1'b0, fill_i} + {1'b0, in_bits_i};
   end

   // Keeps the local width in sync with the package definition.
   logic unused_acc_w;
   assign unused_acc_w = (ACC_W == dsec_pkg::ACC_W);

endmodule : shift_concat_merge

// File: rtl/shift_concat.sv
// -----------------------------------------------------------------------------
// shift_concat
// Packs variable-length compressor chunks into full DATA_W-bit words. Chunks
// are appended LSB-first; every time DATA_W bits are collected a full word is
// emitted. A flush request emits the residual partial word (zero-padded)
// on the first non-stalled cycle after it is taken.
// Ports:
//   clk         in  1       clock, rising edge
//   rst         in  1       asynchronous active-high reset
//   stall       in  1       freeze all state
//   in_valid    in  1       chunk present
//   in_data     in  DATA_W  chunk bits, LSB-aligned
//   in_bits     in  CNT_W   chunk length, legal 0..MAX_CHUNK
//   flush       in  1       request to emit the residual partial word
//   in_rdy      out 1       chunk/flush accepted this cycle
//   out_data    out DATA_W  emitted word, held between emissions
//   out_bits    out CNT_W   valid bits in out_data
//   scon_done   out 1       one-cycle pulse, out_data/out_bits fresh
//   fill        out CNT_W   bits currently held in the accumulator
//   error_bits  out 1       one-cycle pulse, oversize chunk dropped
// -----------------------------------------------------------------------------
module shift_concat #(
   parameter int DATA_W = dsec_pkg::DATA_W,
   parameter int CNT_W  = dsec_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_bits,
   input  logic              flush,
   output logic              in_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_bits,
   output logic              scon_done,
   output logic [CNT_W-1:0]  fill,
   output logic              error_bits
);

   localparam int              ACC_W    = 2 * DATA_W;
   localparam logic [CNT_W:0]  FULL_N   = (CNT_W + 1)'(DATA_W);
   localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] MAX_BITS  = CNT_W'(dsec_pkg::MAX_CHUNK);

   // State
   logic [DATA_W-1:0] acc_q,        acc_d;
   logic [CNT_W-1:0]  fill_q,       fill_d;
   logic              flush_pend_q, flush_pend_d;
   logic [DATA_W-1:0] out_data_q,   out_data_d;
   logic [CNT_W-1:0]  out_bits_q,   out_bits_d;
   logic              scon_done_q,  scon_done_d;
   logic              error_bits_q, error_bits_d;

   // Merge datapath results
   logic [ACC_W-1:0]  combined;
   logic [CNT_W:0]    n;

   logic accept;
   logic chunk_err;
   logic chunk_ok;

   shift_concat_merge #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_merge (
      .acc_i      (acc_q),
      .fill_i     (fill_q),
      .in_data_i  (in_data),
      .in_bits_i  (in_bits),
      .combined_o (combined),
      .n_o        (n)
   );

   // A pending flush blocks new input for exactly the cycle it executes in.
   assign in_rdy = ~stall & ~flush_pend_q;

   always_comb begin
      accept       = in_valid & in_rdy;
      chunk_err    = accept & (in_bits > MAX_BITS);
      // Zero-length chunks are accepted but touch nothing.
      chunk_ok     = accept & ~chunk_err & (in_bits != '0);

      acc_d        = acc_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q;
      out_data_d   = out_data_q;
      out_bits_d   = out_bits_q;
      scon_done_d  = 1'b0;
      error_bits_d = 1'b0;

      if (!stall) begin
         if (flush_pend_q) begin
            // Residual emission; an empty accumulator just clears the request.
            flush_pend_d = 1'b0;
            if (fill_q != '0) begin
               // Accumulator bits above fill are always zero, so it is
               // already the zero-padded residual word.
               out_data_d  = acc_q;
               out_bits_d  = fill_q;
               scon_done_d = 1'b1;
            end
            acc_d  = '0;
            fill_d = '0;
         end else begin
            if (chunk_err) begin
               error_bits_d = 1'b1;
            end else if (chunk_ok) begin
               if (n >= FULL_N) begin
                  out_data_d  = combined[DATA_W-1:0];
                  out_bits_d  = FULL_BITS;
                  scon_done_d = 1'b1;
                  acc_d       = combined[ACC_W-1:DATA_W];
                  fill_d      = CNT_W'(n - FULL_N);
               end else begin
                  acc_d  = combined[DATA_W-1:0];
                  fill_d = CNT_W'(n);
               end
            end
            // A chunk arriving alongside flush is merged first, then the
            // residual goes out on the following non-stalled cycle.
            if (flush) begin
               flush_pend_d = 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   //       samples its _d value from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         out_data_q   <= '0;
         out_bits_q   <= '0;
         scon_done_q  <= 1'b0;
         error_bits_q <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         out_data_q   <= out_data_d;
         out_bits_q   <= out_bits_d;
         scon_done_q  <= scon_done_d;
         error_bits_q <= error_bits_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_bits   = out_bits_q;
   assign scon_done  = scon_done_q;
   assign fill       = fill_q;
   assign error_bits = error_bits_q;

endmodule : shift_concat

// File: tb/tb_shift_concat.sv
// -----------------------------------------------------------------------------
// tb_shift_concat
// Directed stimulus against shift_concat. A bit-queue model tracks the packer
// behaviour at the level of "bits in, 64-bit words out" and is compared with
// the DUT on every falling edge; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_concat;

   localparam int DATA_W = 64;
   localparam int CNT_W  = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [CNT_W-1:0]  in_bits;
   logic              flush;
   logic              in_rdy;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  out_bits;
   logic              scon_done;
   logic [CNT_W-1:0]  fill;
   logic              error_bits;

   int n_checks = 0;
   int n_fail   = 0;

   shift_concat #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_bits    (in_bits),
      .flush      (flush),
      .in_rdy     (in_rdy),
      .out_data   (out_data),
      .out_bits   (out_bits),
      .scon_done  (scon_done),
      .fill       (fill),
      .error_bits (error_bits)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a queue of pending bits -------------
   bit          m_q[$];
   bit          m_pend     = 1'b0;
   logic [63:0] m_out_data = '0;
   int          m_out_bits = 0;
   bit          m_done     = 1'b0;
   bit          m_err      = 1'b0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_pend = 0; m_out_data = '0; m_out_bits = 0; m_done = 0; m_err = 0;
         end else begin
            m_done = 0;
            m_err  = 0;
            if (!stall) begin
               if (m_pend) begin
                  m_pend = 0;
                  if (m_q.size() > 0) begin
                     m_out_data = '0;
                     m_out_bits = m_q.size();
                     for (int i = 0; i < m_out_bits; i++) m_out_data[i] = m_q[i];
                     m_done = 1;
                     m_q.delete();
                  end
               end else begin
                  if (in_valid) begin
                     if (int'(in_bits) > 64) begin
                        m_err = 1;
                     end else begin
                        for (int i = 0; i < int'(in_bits); i++) m_q.push_back(in_data[i]);
                        if (m_q.size() >= 64) begin
                           for (int i = 0; i < 64; i++) m_out_data[i] = m_q.pop_front();
                           m_out_bits = 64;
                           m_done = 1;
                        end
                     end
                  end
                  if (flush) m_pend = 1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle comparison against the model ---------------
   initial begin
      forever begin
         @(negedge clk);
         check("cmp_in_rdy",     64'(in_rdy),     64'(!stall && !m_pend));
         check("cmp_scon_done",  64'(scon_done),  64'(m_done));
         check("cmp_error_bits", 64'(error_bits), 64'(m_err));
         check("cmp_fill",       64'(fill),       64'(m_q.size()));
         check("cmp_out_bits",   64'(out_bits),   64'(m_out_bits));
         check("cmp_out_data",   out_data,        m_out_data);
      end
   end

   // ---------------- directed stimulus ------------------------------------
   // Present inputs for one cycle, then land #1 after the edge that takes them.
   task automatic cyc(input logic v, input logic [63:0] d, input int b,
                      input logic f, input logic s);
      in_valid = v;
      in_data  = d;
      in_bits  = CNT_W'(b);
      flush    = f;
      stall    = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 64'h0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; in_valid = 1'b0; in_data = '0;
      in_bits = '0; flush = 1'b0;
      #2;
      check("rst_fill",      64'(fill),      64'd0);
      check("rst_scon_done", 64'(scon_done), 64'd0);
      check("rst_out_data",  out_data,       64'd0);
      check("rst_in_rdy",    64'(in_rdy),    64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // 40 + 24 bits make exactly one word.
      cyc(1'b1, 64'h0000_00AA_AAAA_AAAA, 40, 1'b0, 1'b0);
      check("w40_fill", 64'(fill),      64'd40);
      check("w40_done", 64'(scon_done), 64'd0);
      cyc(1'b1, 64'h0000_0000_0012_3456, 24, 1'b0, 1'b0);
      check("w64_done", 64'(scon_done), 64'd1);
      check("w64_data", out_data,       64'h1234_56AA_AAAA_AAAA);
      check("w64_bits", 64'(out_bits),  64'd64);
      check("w64_fill", 64'(fill),      64'd0);
      idle();
      check("hold_done", 64'(scon_done), 64'd0);
      check("hold_data", out_data,       64'h1234_56AA_AAAA_AAAA);

      // 60 + 10 bits, junk above in_bits must be masked off.
      cyc(1'b1, 64'hF123_4567_89AB_CDEF, 60, 1'b0, 1'b0);
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_F2B5, 10, 1'b0, 1'b0);
      check("w70_done", 64'(scon_done), 64'd1);
      check("w70_data", out_data,       64'h5123_4567_89AB_CDEF);
      check("w70_fill", 64'(fill),      64'd6);
      cyc(1'b0, 64'h0, 0, 1'b1, 1'b0);
      check("fl_pend_rdy", 64'(in_rdy),    64'd0);
      check("fl_pend_done", 64'(scon_done), 64'd0);
      idle();
      check("fl_done", 64'(scon_done), 64'd1);
      check("fl_bits", 64'(out_bits),  64'd6);
      check("fl_data", out_data,       64'h0000_0000_0000_002B);
      check("fl_fill", 64'(fill),      64'd0);

      // Flush with empty accumulator: nothing emitted, request clears.
      cyc(1'b0, 64'h0, 0, 1'b1, 1'b0);
      idle();
      check("fl0_done", 64'(scon_done), 64'd0);
      check("fl0_rdy",  64'(in_rdy),    64'd1);

      // fill = 30, 64-bit chunk with flush: back-to-back emissions.
      cyc(1'b1, 64'h0000_0000_2AAA_AAAA, 30, 1'b0, 1'b0);
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b0);
      check("b2b_done1", 64'(scon_done), 64'd1);
      check("b2b_bits1", 64'(out_bits),  64'd64);
      check("b2b_data1", out_data,       64'hFFFF_FFFF_EAAA_AAAA);
      check("b2b_rdy",   64'(in_rdy),    64'd0);
      idle();
      check("b2b_done2", 64'(scon_done), 64'd1);
      check("b2b_bits2", 64'(out_bits),  64'd30);
      check("b2b_data2", out_data,       64'h0000_0000_3FFF_FFFF);
      check("b2b_rdy2",  64'(in_rdy),    64'd1);

      // Oversize and zero-length chunks.
      cyc(1'b1, 64'h0000_0000_0000_0ABC, 12, 1'b0, 1'b0);
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
      check("err_pulse", 64'(error_bits), 64'd1);
      check("err_fill",  64'(fill),       64'd12);
      check("err_done",  64'(scon_done),  64'd0);
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0);
      check("err_clear", 64'(error_bits), 64'd0);
      check("zero_fill", 64'(fill),       64'd12);
      cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 127, 1'b0, 1'b0);
      check("err127",    64'(error_bits), 64'd1);

      // Stall with valid held high: nothing moves.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b1);
         check("stall_rdy",  64'(in_rdy),    64'd0);
         check("stall_fill", 64'(fill),      64'd12);
         check("stall_done", 64'(scon_done), 64'd0);
      end

      // Reset mid-accumulation discards the partial word.
      cyc(1'b1, 64'h0000_0000_0000_00FF, 8, 1'b0, 1'b0);
      check("pre_rst_fill", 64'(fill), 64'd20);
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("rst2_fill",   64'(fill),      64'd0);
      check("rst2_done",   64'(scon_done), 64'd0);
      check("rst2_in_rdy", 64'(in_rdy),    64'd1);
      rst = 1'b0;
      idle();
      idle();
      check("post_rst_done", 64'(scon_done), 64'd0);
      check("post_rst_data", out_data,       64'd0);

      // Random-length stream through the model comparison.
      for (int i = 0; i < 200; i++) begin
         cyc(1'($urandom_range(0, 3) != 0),
             {$urandom, $urandom},
             int'($urandom_range(0, 70)),
             1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 7) == 0));
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_shift_concat
